fifo_rd_ctrl: RTL and testbench

Read-side pointer and flag controller for the team's dual-clock FIFO. It runs entirely in the read clock domain and owns the read pointer in both binary and Gray form. It drives the RAM read port, and derives empty, almost-empty and fill level from the write pointer after that pointer has been brought through the two-flop Gray synchronizer. Its Gray read pointer feeds the mirror synchronizer into the write domain.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_ctrl_if.sv | 34 +++
 rtl/fifo_gray2bin.sv | 16 +
 rtl/fifo_rd_ctrl.sv | 73 +++++++
 tb/tb_fifo_rd_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO package: Gray/binary pointer conversion helpers and the default
// address width. Used by both the read-side and write-side controllers.
// Helpers work at a fixed maximum width. Zero-extended inputs convert
// correctly because leading zeros stay zero in both directions. Callers
// truncate the result back to their own pointer width.
package fifo_pkg;

  localparam int unsigned DefAwidth = 3;
  localparam int unsigned PtrMaxW   = 16;

  function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] g);
    logic [PtrMaxW-1:0] b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bus: read request, synchronized write pointer, RAM read port
// and status flags.
//   master : read consumer / environment (drives rdreq_i, wr_pntr_gray_i)
//   slave  : fifo_rd_ctrl (drives pointer, RAM port and flags)
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = DefAwidth
) ();

  logic              rdreq_i;
  logic [AWIDTH:0]   wr_pntr_gray_i;
  logic [AWIDTH:0]   rd_pntr_gray_o;
  logic [AWIDTH-1:0] rd_addr_o;
  logic              rd_en_o;
  logic              rd_valid_o;
  logic              empty_o;
  logic              almost_empty_o;
  logic [AWIDTH:0]   usedw_o;
  logic              underflow_o;

  modport master (
    output rdreq_i, wr_pntr_gray_i,
    input  rd_pntr_gray_o, rd_addr_o, rd_en_o, rd_valid_o,
    input  empty_o, almost_empty_o, usedw_o, underflow_o
  );

  modport slave (
    input  rdreq_i, wr_pntr_gray_i,
    output rd_pntr_gray_o, rd_addr_o, rd_en_o, rd_valid_o,
    output empty_o, almost_empty_o, usedw_o, underflow_o
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary decoder.
//   gray_i : Gray-coded value, Width bits
//   bin_o  : binary value, Width bits
// Each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
  parameter int unsigned Width = 4
) (
  input  logic [Width-1:0] gray_i,
  output logic [Width-1:0] bin_o
);

  for (genvar i = 0; i < Width; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[Width-1:i];
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the dual-clock FIFO (read domain).
//   clk_i  : read-domain clock
//   srst_i : synchronous active-high reset
//   bus    : fifo_rd_ctrl_if.slave -- read request, synchronized Gray write
//            pointer in; Gray read pointer, RAM read port, empty/almost-empty,
//            fill level and underflow out.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = DefAwidth,
  parameter int unsigned AEMPTY = 1
) (
  input logic           clk_i,
  input logic           srst_i,
  fifo_rd_ctrl_if.slave bus
);

  localparam int unsigned PW = AWIDTH + 1;

  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] usedw_q, usedw_d;
  logic [PW-1:0] wr_bin;
  logic          empty_q, aempty_q, valid_q, uflow_q;
  logic          accept;

  fifo_gray2bin #(
    .Width (PW)
  ) u_wr_g2b (
    .gray_i (bus.wr_pntr_gray_i),
    .bin_o  (wr_bin)
  );

  always_comb begin
    // Reset gates the accept so no RAM read is issued while srst_i is high.
    accept    = bus.rdreq_i & ~empty_q & ~srst_i;
    rd_bin_d  = accept ? rd_bin_q + PW'(1) : rd_bin_q;
    rd_gray_d = PW'(bin2gray(PtrMaxW'(rd_bin_d)));
    // Post-read pointer against the current write pointer, so a write that
    // arrives with the last read cancels it out.
    usedw_d   = wr_bin - rd_bin_d;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      usedw_q   <= '0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      valid_q   <= 1'b0;
      uflow_q   <= 1'b0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      usedw_q   <= usedw_d;
      empty_q   <= (usedw_d == '0);
      aempty_q  <= (usedw_d <= PW'(AEMPTY));
      valid_q   <= accept;
      uflow_q   <= bus.rdreq_i & empty_q;
    end
  end

  assign bus.rd_en_o        = accept;
  assign bus.rd_addr_o      = rd_bin_q[AWIDTH-1:0];
  assign bus.rd_pntr_gray_o = rd_gray_q;
  assign bus.rd_valid_o     = valid_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_empty_o = aempty_q;
  assign bus.usedw_o        = usedw_q;
  assign bus.underflow_o    = uflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl at AWIDTH=3, AEMPTY=1.
module tb_fifo_rd_ctrl;

  logic clk_i = 1'b0;
  logic srst_i;
  int   n_total = 0;
  int   n_bad   = 0;

  // Scoreboard for the write/read pair runs.
  int unsigned m_rd;
  int unsigned m_used;
  logic        m_empty;

  always #5 clk_i = ~clk_i;

  fifo_rd_ctrl_if #(.AWIDTH(3)) bus ();

  fifo_rd_ctrl #(
    .AWIDTH (3),
    .AEMPTY (1)
  ) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] gray4(input int unsigned b);
    logic [3:0] v;
    v = 4'(b % 16);
    return v ^ (v >> 1);
  endfunction

  // One cycle with a read request and a write pointer value, checked against
  // the scoreboard after the edge.
  task automatic pair(input logic rd, input int unsigned wr);
    logic acc;
    bus.rdreq_i        = rd;
    bus.wr_pntr_gray_i = gray4(wr);
    acc = rd && !m_empty;
    #1;
    check("pair_rd_en", 32'(bus.rd_en_o), 32'(acc));
    check("pair_rd_addr", 32'(bus.rd_addr_o), m_rd % 8);
    tick();
    m_rd    = (m_rd + (acc ? 1 : 0)) % 16;
    m_used  = ((wr % 16) + 16 - m_rd) % 16;
    m_empty = (m_used == 0);
    check("pair_usedw", 32'(bus.usedw_o), m_used);
    check("pair_empty", 32'(bus.empty_o), 32'(m_empty));
    check("pair_valid", 32'(bus.rd_valid_o), 32'(acc));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"},  32'(bus.empty_o), 32'd1);
    check({tag, "_aempty"}, 32'(bus.almost_empty_o), 32'd1);
    check({tag, "_usedw"},  32'(bus.usedw_o), 32'd0);
    check({tag, "_gray"},   32'(bus.rd_pntr_gray_o), 32'd0);
    check({tag, "_valid"},  32'(bus.rd_valid_o), 32'd0);
    check({tag, "_uflow"},  32'(bus.underflow_o), 32'd0);
  endtask

  initial begin
    // Reset
    srst_i             = 1'b1;
    bus.rdreq_i        = 1'b0;
    bus.wr_pntr_gray_i = 4'b0000;
    tick();
    tick();
    check_reset_vals("rst");
    check("rst_rd_en", 32'(bus.rd_en_o), 32'd0);

    // Basic drain: two words
    srst_i             = 1'b0;
    bus.wr_pntr_gray_i = 4'b0011;
    tick();
    check("drain_usedw2", 32'(bus.usedw_o), 32'd2);
    check("drain_empty0", 32'(bus.empty_o), 32'd0);
    check("drain_aempty0", 32'(bus.almost_empty_o), 32'd0);
    bus.rdreq_i = 1'b1;
    #1;
    check("drain_en1", 32'(bus.rd_en_o), 32'd1);
    check("drain_addr0", 32'(bus.rd_addr_o), 32'd0);
    tick();
    check("drain_valid1", 32'(bus.rd_valid_o), 32'd1);
    check("drain_usedw1", 32'(bus.usedw_o), 32'd1);
    check("drain_aempty1", 32'(bus.almost_empty_o), 32'd1);
    check("drain_addr1", 32'(bus.rd_addr_o), 32'd1);
    check("drain_gray1", 32'(bus.rd_pntr_gray_o), 32'b0001);
    check("drain_en2", 32'(bus.rd_en_o), 32'd1);
    tick();
    check("drain_valid2", 32'(bus.rd_valid_o), 32'd1);
    check("drain_empty1", 32'(bus.empty_o), 32'd1);
    check("drain_usedw0", 32'(bus.usedw_o), 32'd0);
    check("drain_gray2", 32'(bus.rd_pntr_gray_o), 32'b0011);
    check("drain_uflow0", 32'(bus.underflow_o), 32'd0);

    // Underflow: request held while empty
    check("uf_en0", 32'(bus.rd_en_o), 32'd0);
    tick();
    check("uf_pulse", 32'(bus.underflow_o), 32'd1);
    check("uf_valid0", 32'(bus.rd_valid_o), 32'd0);
    check("uf_gray", 32'(bus.rd_pntr_gray_o), 32'b0011);
    check("uf_addr", 32'(bus.rd_addr_o), 32'd2);
    bus.rdreq_i = 1'b0;
    tick();
    check("uf_end", 32'(bus.underflow_o), 32'd0);

    // Full level with read pointer at 0
    srst_i             = 1'b1;
    bus.wr_pntr_gray_i = 4'b0000;
    tick();
    srst_i             = 1'b0;
    bus.wr_pntr_gray_i = 4'b1100;
    tick();
    check("full_usedw8", 32'(bus.usedw_o), 32'd8);
    check("full_empty0", 32'(bus.empty_o), 32'd0);
    check("full_aempty0", 32'(bus.almost_empty_o), 32'd0);

    // 20 write/read pairs across the 15 -> 0 wrap
    m_rd    = 0;
    m_used  = 8;
    m_empty = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      pair(1'b1, 8 + i);
    end
    check("wrap_rd_gray", 32'(bus.rd_pntr_gray_o), 32'(gray4(20)));

    // Drain with write pointer parked at 12 down to one word
    for (int i = 0; i < 7; i++) begin
      pair(1'b1, 12);
    end
    check("simul_pre_usedw1", 32'(bus.usedw_o), 32'd1);

    // Last read and write advance in the same cycle
    bus.rdreq_i        = 1'b1;
    bus.wr_pntr_gray_i = 4'b1011;
    tick();
    check("simul_usedw1", 32'(bus.usedw_o), 32'd1);
    check("simul_empty0", 32'(bus.empty_o), 32'd0);
    check("simul_valid", 32'(bus.rd_valid_o), 32'd1);
    check("simul_gray", 32'(bus.rd_pntr_gray_o), 32'b1010);

    // Reset mid-operation with five words and a pending read
    bus.rdreq_i        = 1'b0;
    bus.wr_pntr_gray_i = 4'b0001;
    tick();
    check("mid_usedw5", 32'(bus.usedw_o), 32'd5);
    srst_i      = 1'b1;
    bus.rdreq_i = 1'b1;
    #1;
    check("mid_en0", 32'(bus.rd_en_o), 32'd0);
    tick();
    check_reset_vals("mid");
    srst_i      = 1'b0;
    bus.rdreq_i = 1'b0;
    tick();
    check("mid_post_valid", 32'(bus.rd_valid_o), 32'd0);
    check("mid_post_usedw", 32'(bus.usedw_o), 32'd1);
    check("mid_post_empty", 32'(bus.empty_o), 32'd0);
    check("mid_post_aempty", 32'(bus.almost_empty_o), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
